// File: rtl/usermem_arbiter_pkg.sv
// Shared types and constants for the user-memory arbiter: FSM encoding, port ids, bus widths.
// Also provides a helper that extracts one port's byte from a packed {port1, port0} bus.
package usermem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int NPORT  = 2;
  localparam int LAT_W  = 2;

  localparam logic PORT_DMA = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic              id;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } slot_t;

  function automatic logic [DATA_W-1:0] port_field(input logic [NPORT*DATA_W-1:0] v,
                                                   input logic                     id);
    return id ? v[2*DATA_W-1:DATA_W] : v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/usermem_arbiter_if.sv
// Bus bundle between control unit, secondary requesters, arbiter and user memory macro.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface usermem_arbiter_if;
  import usermem_pkg::*;

  logic                    cpu_req;
  logic                    cpu_rw;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [DATA_W-1:0]       cpu_wdata;
  logic [DATA_W-1:0]       cpu_rdata;

  logic [NPORT-1:0]        p_req;
  logic [NPORT-1:0]        p_rw;
  logic [NPORT*ADDR_W-1:0] p_addr;
  logic [NPORT*DATA_W-1:0] p_wdata;
  logic [NPORT-1:0]        p_gnt;
  logic [NPORT-1:0]        p_rvalid;
  logic [DATA_W-1:0]       p_rdata;

  logic                    mem_rw;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  logic                    busy;
  logic                    starve;

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_rdata,
    input  p_req, p_rw, p_addr, p_wdata,
    output p_gnt, p_rvalid, p_rdata,
    output mem_rw, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, starve
  );

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_rdata,
    output p_req, p_rw, p_addr, p_wdata,
    input  p_gnt, p_rvalid, p_rdata,
    input  mem_rw, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, starve
  );

endinterface

// File: rtl/usermem_arbiter_rr_arb2.sv
// Combinational two-input round-robin picker: on contention the port that did not win last goes next.
// Zero latency; no state of its own, the caller keeps the last-winner register.
module rr_arb2
  import usermem_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic             last,
  output logic             id,
  output logic             valid
);

  always_comb begin
    valid = |req;
    id    = PORT_DMA;
    if (&req) begin
      id = ~last;
    end else if (req[PORT_DBG]) begin
      id = PORT_DBG;
    end
  end

endmodule

// File: rtl/usermem_arbiter.sv
// Shares the user memory: CPU passes through combinationally with absolute priority, DMA/debug are round-robin.
// Secondary grant 1 cycle after request when the CPU is idle, read data MEM_LAT+1 cycles after grant; CPU traffic stalls the slot.
module usermem_arbiter
  import usermem_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  usermem_arbiter_if.slave bus
);

  localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LAT - 1);

  state_t            r_state;
  slot_t             r_slot;
  logic              r_rr_last;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_starve;
  logic [DATA_W-1:0] r_p_rdata;
  logic [NPORT-1:0]  r_p_rvalid;

  logic              w_win_id;
  logic              w_win_vld;
  logic              w_issue;

  rr_arb2 u_rr_arb2 (
    .req   (bus.p_req),
    .last  (r_rr_last),
    .id    (w_win_id),
    .valid (w_win_vld)
  );

  // The slot only reaches the bus in a cycle the CPU leaves free.
  assign w_issue = (r_state == ISSUE) && !bus.cpu_req;

  always_comb begin
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (bus.cpu_req) begin
      bus.mem_rw    = bus.cpu_rw;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (r_state == ISSUE) begin
      bus.mem_rw    = r_slot.rw;
      bus.mem_addr  = r_slot.addr;
      bus.mem_wdata = r_slot.wdata;
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.p_gnt     = {w_issue & r_slot.id, w_issue & ~r_slot.id};
  assign bus.p_rvalid  = r_p_rvalid;
  assign bus.p_rdata   = r_p_rdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.starve    = r_starve;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_slot       <= '0;
      r_rr_last    <= 1'b1;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
      r_p_rdata    <= '0;
      r_p_rvalid   <= '0;
    end else begin
      r_p_rvalid <= '0;
      if (r_starve_cnt == CNT_MAX) begin
        r_starve <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_slot  <= '{id:    w_win_id,
                         rw:    bus.p_rw[w_win_id],
                         addr:  port_field(bus.p_addr, w_win_id),
                         wdata: port_field(bus.p_wdata, w_win_id)};
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cpu_req) begin
            if (r_starve_cnt != CNT_MAX) begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end else begin
            r_starve_cnt <= '0;
            r_rr_last    <= r_slot.id;
            if (r_slot.rw) begin
              r_state <= IDLE;
            end else begin
              r_lat_cnt <= LAT_LOAD;
              r_state   <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          // The memory pipeline delivers this slot's data at a fixed offset even if the CPU used the bus meanwhile.
          if (r_lat_cnt == '0) begin
            r_p_rdata  <= bus.mem_rdata;
            r_p_rvalid <= {r_slot.id, ~r_slot.id};
            r_state    <= IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usermem_arbiter.sv
// Self-checking bench for usermem_arbiter with a pipelined memory model (MEM_LAT=2) and grant/read scoreboards.
module tb_usermem_arbiter;

  localparam int MEM_LAT      = 2;
  localparam int STARVE_LIMIT = 15;

  typedef struct packed {
    logic [1:0] gnt;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_gnt_t;

  typedef struct packed {
    logic [1:0] rvalid;
    logic [7:0] rdata;
  } exp_rd_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_gnt_t gnt_q[$];
  exp_rd_t  rd_q[$];

  always #5 clk = ~clk;

  usermem_arbiter_if bus();

  usermem_arbiter #(
    .MEM_LAT      (MEM_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem     [256];
  logic [7:0] rd_pipe [MEM_LAT];

  always @(posedge clk) begin
    if (bus.mem_rw) mem[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = 8'h00;
    bus.cpu_wdata = 8'h00;
    bus.p_req     = 2'b00;
    bus.p_rw      = 2'b00;
    bus.p_addr    = 16'h0000;
    bus.p_wdata   = 16'h0000;
  endtask

  function automatic logic [7:0] rr_addr(input int p, input int k);
    return 8'(8'h40 + 16 * p + k);
  endfunction

  function automatic logic [7:0] rr_data(input int p, input int k);
    return 8'(8'hA1 + 16 * p + k);
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.p_gnt, bus.p_rvalid, bus.p_rdata, bus.busy, bus.starve,
         bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h busy=%b starve=%b mem_rw=%b addr=%h wdata=%h, required all 0",
               bus.p_gnt, bus.p_rvalid, bus.p_rdata, bus.busy, bus.starve, bus.mem_rw, bus.mem_addr, bus.mem_wdata);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_cpu_passthrough();
    bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'hA5;
    @(negedge clk);
    checks++;
    if ({bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h10, 8'hA5}) begin
      errors++;
      $display("FAIL cpu_write_mirror: rw=%b addr=%h wdata=%h, required 1/10/a5", bus.mem_rw, bus.mem_addr, bus.mem_wdata);
    end
    step();
    bus.cpu_addr = 8'h22; bus.cpu_wdata = 8'h3C;
    step();
    bus.cpu_rw = 1'b0; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'hFF;
    @(negedge clk);
    checks++;
    if ({bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== {1'b0, 8'h10, 8'hFF}) begin
      errors++;
      $display("FAIL cpu_read_mirror: rw=%b addr=%h wdata=%h, required 0/10/ff", bus.mem_rw, bus.mem_addr, bus.mem_wdata);
    end
    step();
    bus.cpu_addr = 8'h22;
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_rdata_10: got %h, required a5", bus.cpu_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL cpu_rdata_22: got %h, required 3c", bus.cpu_rdata);
    end
    step();
  endtask

  task automatic test_round_robin();
    int       k [2];
    int       n;
    exp_gnt_t e;
    k[0] = 0; k[1] = 0; n = 0;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++)
        gnt_q.push_back('{gnt: 2'(1 << p), rw: 1'b1, addr: rr_addr(p, i), wdata: rr_data(p, i)});
    for (int cyc = 0; cyc < 24 && gnt_q.size() != 0; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        bus.p_req[p]          = (k[p] < 2);
        bus.p_rw[p]           = 1'b1;
        bus.p_addr[p*8 +: 8]  = rr_addr(p, k[p]);
        bus.p_wdata[p*8 +: 8] = rr_data(p, k[p]);
      end
      @(negedge clk);
      if (bus.p_gnt !== 2'b00) begin
        e = gnt_q.pop_front();
        checks++;
        if ({bus.p_gnt, bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== e) begin
          errors++;
          $display("FAIL rr_grant%0d: gnt=%b rw=%b addr=%h wdata=%h, required gnt=%b rw=%b addr=%h wdata=%h",
                   n, bus.p_gnt, bus.mem_rw, bus.mem_addr, bus.mem_wdata, e.gnt, e.rw, e.addr, e.wdata);
        end
        checks++;
        if (cyc != 1 + 2 * n) begin
          errors++;
          $display("FAIL rr_spacing%0d: grant at cycle %0d, required %0d", n, cyc, 1 + 2 * n);
        end
        k[bus.p_gnt[1]]++;
        n++;
      end
      step();
    end
    bus.p_req = 2'b00;
    checks++;
    if (gnt_q.size() != 0) begin
      errors++;
      $display("FAIL rr_timeout: %0d grants missing, required 0", gnt_q.size());
      gnt_q.delete();
    end
    step();
  endtask

  task automatic test_secondary_read();
    bit      got_gnt;
    exp_rd_t r;
    got_gnt = 1'b0;
    bus.p_req = 2'b10; bus.p_rw = 2'b00; bus.p_addr = {8'h10, 8'h00};
    rd_q.push_back('{rvalid: 2'b10, rdata: 8'hA5});
    for (int cyc = 0; cyc < 16 && rd_q.size() != 0; cyc++) begin
      if (got_gnt) bus.p_req = 2'b00;
      // CPU write during the read wait must not disturb the returned data.
      bus.cpu_req = (cyc == 2); bus.cpu_rw = 1'b1; bus.cpu_addr = 8'h77; bus.cpu_wdata = 8'h5A;
      @(negedge clk);
      if (cyc == 2) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL rd_busy: got %b, required 1", bus.busy);
        end
      end
      if (bus.p_gnt !== 2'b00) begin
        checks++;
        if ({bus.p_gnt, bus.mem_rw, bus.mem_addr} !== {2'b10, 1'b0, 8'h10} || cyc != 1) begin
          errors++;
          $display("FAIL rd_grant: gnt=%b rw=%b addr=%h cycle=%0d, required gnt=10 rw=0 addr=10 cycle=1",
                   bus.p_gnt, bus.mem_rw, bus.mem_addr, cyc);
        end
        got_gnt = 1'b1;
      end
      if (bus.p_rvalid !== 2'b00) begin
        r = rd_q.pop_front();
        checks++;
        if ({bus.p_rvalid, bus.p_rdata} !== r) begin
          errors++;
          $display("FAIL rd_data: rvalid=%b rdata=%h, required rvalid=%b rdata=%h", bus.p_rvalid, bus.p_rdata, r.rvalid, r.rdata);
        end
        checks++;
        if (cyc != MEM_LAT + 2) begin
          errors++;
          $display("FAIL rd_latency: rvalid at cycle %0d, required %0d", cyc, MEM_LAT + 2);
        end
      end
      step();
    end
    idle_inputs();
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_timeout: %0d reads missing, required 0", rd_q.size());
      rd_q.delete();
    end
    step();
  endtask

  task automatic test_cpu_preempt_or_starve(input int cpu_first, input int cpu_last,
                                            input logic [7:0] addr, input logic [7:0] data,
                                            input logic exp_starve);
    bit       got_gnt;
    exp_gnt_t e;
    got_gnt = 1'b0;
    bus.p_req = 2'b01; bus.p_rw = 2'b01; bus.p_addr = {8'h00, addr}; bus.p_wdata = {8'h00, data};
    gnt_q.push_back('{gnt: 2'b01, rw: 1'b1, addr: addr, wdata: data});
    for (int cyc = 0; cyc < 40 && gnt_q.size() != 0; cyc++) begin
      if (got_gnt) bus.p_req = 2'b00;
      bus.cpu_req = (cyc >= cpu_first && cyc <= cpu_last); bus.cpu_rw = 1'b0; bus.cpu_addr = 8'h10;
      @(negedge clk);
      if (bus.p_gnt !== 2'b00) begin
        e = gnt_q.pop_front();
        checks++;
        if ({bus.p_gnt, bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== e || cyc != cpu_last + 1) begin
          errors++;
          $display("FAIL hold_grant_%h: gnt=%b rw=%b addr=%h wdata=%h cycle=%0d, required gnt=01 addr=%h wdata=%h cycle=%0d",
                   addr, bus.p_gnt, bus.mem_rw, bus.mem_addr, bus.mem_wdata, cyc, e.addr, e.wdata, cpu_last + 1);
        end
        got_gnt = 1'b1;
      end
      step();
    end
    idle_inputs();
    checks++;
    if (gnt_q.size() != 0) begin
      errors++;
      $display("FAIL hold_timeout_%h: %0d grants missing, required 0", addr, gnt_q.size());
      gnt_q.delete();
    end
    repeat (3) step();
    checks++;
    if (bus.starve !== exp_starve) begin
      errors++;
      $display("FAIL starve_%h: got %b, required %b", addr, bus.starve, exp_starve);
    end
    bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = addr;
    step();
    bus.cpu_req = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== data) begin
      errors++;
      $display("FAIL hold_memdata_%h: got %h, required %h", addr, bus.cpu_rdata, data);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    bit seen_rvalid;
    seen_rvalid = 1'b0;
    bus.p_req = 2'b01; bus.p_rw = 2'b00; bus.p_addr = {8'h00, 8'h10};
    step();
    bus.p_req = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.p_gnt !== 2'b01) begin
      errors++;
      $display("FAIL mid_grant: got %b, required 01", bus.p_gnt);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.p_gnt, bus.p_rvalid, bus.p_rdata, bus.busy, bus.starve,
         bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== 37'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: gnt=%b rvalid=%b rdata=%h busy=%b starve=%b mem_rw=%b, required all 0",
               bus.p_gnt, bus.p_rvalid, bus.p_rdata, bus.busy, bus.starve, bus.mem_rw);
    end
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.p_rvalid !== 2'b00) seen_rvalid = 1'b1;
      step();
    end
    checks++;
    if (seen_rvalid) begin
      errors++;
      $display("FAIL abandoned_rvalid: rvalid seen after reset, required none");
    end
    bus.p_req = 2'b11; bus.p_rw = 2'b11; bus.p_addr = {8'h81, 8'h80}; bus.p_wdata = {8'h02, 8'h01};
    step();
    bus.p_req = 2'b10;
    @(negedge clk);
    checks++;
    if ({bus.p_gnt, bus.mem_addr, bus.mem_wdata} !== {2'b01, 8'h80, 8'h01}) begin
      errors++;
      $display("FAIL post_reset_first: gnt=%b addr=%h wdata=%h, required 01/80/01", bus.p_gnt, bus.mem_addr, bus.mem_wdata);
    end
    step();
    step();
    @(negedge clk);
    checks++;
    if ({bus.p_gnt, bus.mem_addr, bus.mem_wdata} !== {2'b10, 8'h81, 8'h02}) begin
      errors++;
      $display("FAIL post_reset_second: gnt=%b addr=%h wdata=%h, required 10/81/02", bus.p_gnt, bus.mem_addr, bus.mem_wdata);
    end
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_passthrough();
    test_round_robin();
    test_secondary_read();
    test_cpu_preempt_or_starve(1, 5, 8'h55, 8'h99, 1'b0);
    test_cpu_preempt_or_starve(0, 16, 8'h66, 8'h77, 1'b1);
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
